// File: rtl/regs_wb_ctrl_pkg.sv
// Shared register-file defines for the integer write-back path.
// Widths, register count and write-back source indices.
package regs_wb_ctrl_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_DEPTH = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: valid in, one-hot grant out.
// The pointer holds the last grant; reset gives source 0 first priority.
module rr_arbiter
  import regs_wb_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] valid_i,
  output logic [NUM_SRC-1:0] grant_o
);

  localparam int IW = (NUM_SRC > 2) ? 2 : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;

  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    last_d  = last_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_q) + k) % NUM_SRC;
      if ((grant_o == '0) && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        last_d       = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(NUM_SRC - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Register-file write-back arbiter and RAW/WAW hazard scoreboard.
// Define REGS_WB_FWD_EN to forward the write-port value to issue reads.
module regs_wb_ctrl
  import regs_wb_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH      = regs_wb_ctrl_pkg::CPU_WIDTH,
  parameter int REG_ADDR_WIDTH = regs_wb_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int REG_DATA_DEPTH = regs_wb_ctrl_pkg::REG_DATA_DEPTH,
  parameter int NUM_SRC        = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  input  logic                          issue_rd_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0]     issue_rd_i,
  input  logic [REG_ADDR_WIDTH-1:0]     issue_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]     issue_rs2_i,
  output logic                          issue_stall_o,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr_i,
  input  logic [NUM_SRC*CPU_WIDTH-1:0]  src_data_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  output logic                          reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0]     reg_wr_adder_o,
  output logic [CPU_WIDTH-1:0]          reg_wr_data_o,
  output logic [REG_DATA_DEPTH-1:0]     busy_o
`ifdef REGS_WB_FWD_EN
  ,
  input  logic [CPU_WIDTH-1:0]          rs1_data_i,
  input  logic [CPU_WIDTH-1:0]          rs2_data_i,
  output logic [CPU_WIDTH-1:0]          rs1_data_o,
  output logic [CPU_WIDTH-1:0]          rs2_data_o
`endif
);

  logic [NUM_SRC-1:0]        grant;
  logic                      hs;
  logic [REG_ADDR_WIDTH-1:0] hs_addr;
  logic [CPU_WIDTH-1:0]      hs_data;

  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CPU_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [REG_DATA_DEPTH-1:0] busy_q, busy_d;

  logic h1, h2, hw, fwd1, fwd2, issue_acc;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (src_valid_i),
    .grant_o (grant)
  );

  assign src_ready_o = grant;

  always_comb begin
    hs      = 1'b0;
    hs_addr = '0;
    hs_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        hs      = 1'b1;
        hs_addr = src_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        hs_data = src_data_i[i*CPU_WIDTH +: CPU_WIDTH];
      end
    end
  end

  // x0 results complete the handshake but never reach the file
  always_comb begin
    wr_en_d   = hs && (hs_addr != '0);
    wr_addr_d = hs ? hs_addr : wr_addr_q;
    wr_data_d = hs ? hs_data : wr_data_q;
  end

`ifdef REGS_WB_FWD_EN
  assign fwd1 = wr_en_q && (wr_addr_q == issue_rs1_i);
  assign fwd2 = wr_en_q && (wr_addr_q == issue_rs2_i);
  assign rs1_data_o = fwd1 ? wr_data_q : rs1_data_i;
  assign rs2_data_o = fwd2 ? wr_data_q : rs2_data_i;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign h1 = (issue_rs1_i != '0) && busy_q[issue_rs1_i] && !fwd1;
  assign h2 = (issue_rs2_i != '0) && busy_q[issue_rs2_i] && !fwd2;
  assign hw = issue_rd_wen_i && (issue_rd_i != '0) && busy_q[issue_rd_i];

  assign issue_stall_o = issue_valid_i && (h1 || h2 || hw);
  assign issue_acc     = issue_valid_i && !issue_stall_o;

  // set is applied after clear so it wins on a shared register
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (issue_acc && issue_rd_wen_i && (issue_rd_i != '0))
      busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign reg_wr_en_o    = wr_en_q;
  assign reg_wr_adder_o = wr_addr_q;
  assign reg_wr_data_o  = wr_data_q;
  assign busy_o         = busy_q;

  a_wb_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (hs && (hs_addr != '0)) |-> busy_q[hs_addr]);

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Self-checking bench for regs_wb_ctrl: directed scenarios
// plus a randomized run against a scoreboard model.
module tb_regs_wb_ctrl;
  import regs_wb_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_wen;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic [2:0]  src_valid;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic [2:0]  src_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;
`ifdef REGS_WB_FWD_EN
  logic [31:0] rs1_di, rs2_di, rs1_do, rs2_do;
`endif

  int errors = 0;
  int checks = 0;

  regs_wb_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_rd_wen_i (issue_wen),
    .issue_rd_i     (issue_rd),
    .issue_rs1_i    (issue_rs1),
    .issue_rs2_i    (issue_rs2),
    .issue_stall_o  (issue_stall),
    .src_valid_i    (src_valid),
    .src_addr_i     (src_addr),
    .src_data_i     (src_data),
    .src_ready_o    (src_ready),
    .reg_wr_en_o    (wr_en),
    .reg_wr_adder_o (wr_addr),
    .reg_wr_data_o  (wr_data),
    .busy_o         (busy)
`ifdef REGS_WB_FWD_EN
    ,
    .rs1_data_i     (rs1_di),
    .rs2_data_i     (rs2_di),
    .rs1_data_o     (rs1_do),
    .rs2_data_o     (rs2_do)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
    src_valid[i]        = v;
    src_addr[i*5 +: 5]  = a;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic set_issue(input logic v, input logic wen, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v;
    issue_wen   = wen;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    set_issue(0, 0, 0, 0, 0);
`ifdef REGS_WB_FWD_EN
    rs1_di = '0;
    rs2_di = '0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 32'h0) begin errors++;
      $display("FAIL reset_busy: got %h expected %h", busy, 32'h0); end
    checks++; if (wr_en !== 1'b0) begin errors++;
      $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++;
      $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++;
      $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (src_ready !== 3'b000) begin errors++;
      $display("FAIL reset_ready: got %b expected 000", src_ready); end
    checks++; if (issue_stall !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b expected 0", issue_stall); end
  endtask

  task automatic test_single_write();
    set_issue(1, 1, 5, 0, 0);
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++;
      $display("FAIL single_stall: got %b expected 0", issue_stall); end
    tick();
    set_issue(0, 0, 0, 0, 0);
    checks++; if (busy !== 32'h20) begin errors++;
      $display("FAIL single_busy_set: got %h expected %h", busy, 32'h20); end
    set_src(SRC_ALU, 1, 5, 32'hDEADBEEF);
    #1;
    checks++; if (src_ready !== 3'b001) begin errors++;
      $display("FAIL single_ready: got %b expected 001", src_ready); end
    tick();
    set_src(SRC_ALU, 0, 0, 0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_wport: got en=%b a=%0d d=%h expected en=1 a=5 d=deadbeef",
               wr_en, wr_addr, wr_data); end
    checks++; if (busy !== 32'h20) begin errors++;
      $display("FAIL single_busy_hold: got %h expected %h", busy, 32'h20); end
    tick();
    checks++; if (busy !== 32'h0 || wr_en !== 1'b0) begin errors++;
      $display("FAIL single_clear: got busy=%h en=%b expected 0 0", busy, wr_en); end
  endtask

  task automatic test_raw_stall();
    set_issue(1, 1, 7, 0, 0);
    tick();
    set_issue(1, 0, 0, 0, 7);
`ifdef REGS_WB_FWD_EN
    rs2_di = 32'h11111111;
`endif
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++;
      $display("FAIL raw_stall0: got %b expected 1", issue_stall); end
    tick();
    set_src(SRC_LSU, 1, 7, 32'hCAFE0007);
    #1;
    checks++; if (issue_stall !== 1'b1 || src_ready !== 3'b010) begin errors++;
      $display("FAIL raw_stall1: got stall=%b rdy=%b expected 1 010",
               issue_stall, src_ready); end
    tick();
    set_src(SRC_LSU, 0, 0, 0);
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++;
      $display("FAIL raw_wr_en: got %b expected 1", wr_en); end
`ifdef REGS_WB_FWD_EN
    checks++; if (issue_stall !== 1'b0) begin errors++;
      $display("FAIL raw_fwd_stall: got %b expected 0", issue_stall); end
    checks++; if (rs2_do !== 32'hCAFE0007) begin errors++;
      $display("FAIL raw_fwd_data: got %h expected cafe0007", rs2_do); end
    tick();
`else
    checks++; if (issue_stall !== 1'b1) begin errors++;
      $display("FAIL raw_wr_cycle_stall: got %b expected 1", issue_stall); end
    tick();
    checks++; if (issue_stall !== 1'b0) begin errors++;
      $display("FAIL raw_release: got %b expected 0", issue_stall); end
    tick();
`endif
    set_issue(0, 0, 0, 0, 0);
    checks++; if (busy !== 32'h0) begin errors++;
      $display("FAIL raw_busy_end: got %h expected 0", busy); end
  endtask

  task automatic test_x0();
    set_src(SRC_MDU, 1, 0, 32'h1234);
    #1;
    checks++; if (src_ready !== 3'b100) begin errors++;
      $display("FAIL x0_ready: got %b expected 100", src_ready); end
    tick();
    set_src(SRC_MDU, 0, 0, 0);
    checks++; if (wr_en !== 1'b0 || busy !== 32'h0) begin errors++;
      $display("FAIL x0_discard: got en=%b busy=%h expected 0 0", wr_en, busy); end
    checks++; if (wr_data !== 32'h1234) begin errors++;
      $display("FAIL x0_data: got %h expected 1234", wr_data); end
  endtask

  task automatic test_waw();
    set_issue(1, 1, 3, 0, 0);
    tick();
    #1;
    checks++; if (issue_stall !== 1'b1 || busy !== 32'h8) begin errors++;
      $display("FAIL waw_stall: got stall=%b busy=%h expected 1 8", issue_stall, busy); end
    set_src(SRC_ALU, 1, 3, 32'h33);
    #1;
    checks++; if (src_ready !== 3'b001) begin errors++;
      $display("FAIL waw_ready: got %b expected 001", src_ready); end
    tick();
    set_src(SRC_ALU, 0, 0, 0);
    #1;
    checks++; if (wr_en !== 1'b1 || issue_stall !== 1'b1) begin errors++;
      $display("FAIL waw_wr_cycle: got en=%b stall=%b expected 1 1", wr_en, issue_stall); end
    tick();
    checks++; if (busy !== 32'h0 || issue_stall !== 1'b0) begin errors++;
      $display("FAIL waw_release: got busy=%h stall=%b expected 0 0", busy, issue_stall); end
    tick();
    set_issue(0, 0, 0, 0, 0);
    checks++; if (busy !== 32'h8) begin errors++;
      $display("FAIL waw_reset_busy: got %h expected 8", busy); end
    set_src(SRC_LSU, 1, 3, 32'h0);
    tick();
    set_src(SRC_LSU, 0, 0, 0);
    tick();
    checks++; if (busy !== 32'h0) begin errors++;
      $display("FAIL waw_cleanup: got %h expected 0", busy); end
  endtask

  task automatic test_fairness();
    int cnt[3];
    int g;
    logic [4:0] a;
    do_reset();
    for (int r = 10; r < 16; r++) begin
      set_issue(1, 1, 5'(r), 0, 0);
      tick();
    end
    set_issue(0, 0, 0, 0, 0);
    checks++; if (busy !== 32'h0000FC00) begin errors++;
      $display("FAIL rr_busy: got %h expected 0000fc00", busy); end
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      set_src(i, 1, 5'(10 + i), 32'hF0000000 + 32'(10 + i));
    end
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      #1;
      checks++; if (src_ready !== 3'(1 << g)) begin errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", c, src_ready, 3'(1 << g)); end
      tick();
      cnt[g]++;
      a = 5'(10 + g + 3 * cnt[g]);
      if (cnt[g] < 2) set_src(g, 1, a, 32'hF0000000 + 32'(a));
      else set_src(g, 0, 0, 0);
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'(10 + c)
                    || wr_data !== 32'hF0000000 + 32'(10 + c)) begin errors++;
        $display("FAIL rr_wport%0d: got en=%b a=%0d d=%h expected a=%0d",
                 c, wr_en, wr_addr, wr_data, 10 + c); end
    end
    tick();
    checks++; if (busy !== 32'h0) begin errors++;
      $display("FAIL rr_busy_end: got %h expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    set_issue(1, 1, 4, 0, 0);
    tick();
    set_issue(1, 1, 9, 0, 0);
    tick();
    set_issue(0, 0, 0, 0, 0);
    set_src(SRC_ALU, 1, 4, 32'h44);
    tick();
    set_src(SRC_ALU, 0, 0, 0);
    checks++; if (wr_en !== 1'b1 || busy !== 32'h210) begin errors++;
      $display("FAIL mid_pre: got en=%b busy=%h expected 1 210", wr_en, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 32'h0 || wr_en !== 1'b0 || wr_addr !== 5'd0
                  || wr_data !== 32'h0 || src_ready !== 3'b000) begin errors++;
      $display("FAIL mid_async: got busy=%h en=%b a=%0d d=%h rdy=%b expected zeros",
               busy, wr_en, wr_addr, wr_data, src_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) set_src(i, 1, 0, 32'(i));
    #1;
    checks++; if (src_ready !== 3'b001) begin errors++;
      $display("FAIL mid_first_grant: got %b expected 001", src_ready); end
    tick();
    src_valid = '0;
  endtask

  task automatic test_random();
    bit          mb[32];
    int          last;
    bit          men;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic [4:0]  pend[$];
    bit          sv[3];
    logic [4:0]  sa[3];
    logic [31:0] sd[3];
    logic [31:0] eb;
    int          g, k, j;
    bit          iv, wen, es, acc;
    logic [4:0]  rd, r1, r2;
    do_reset();
    last = 2;
    men = 0;
    maddr = 0;
    mdata = 0;
    for (int i = 0; i < 32; i++) mb[i] = 0;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 0; sa[i] = 0; sd[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!sv[i] && $urandom_range(0, 2) == 0) begin
          if (pend.size() > 0) begin
            k = $urandom_range(0, pend.size() - 1);
            sa[i] = pend[k];
            pend.delete(k);
            sv[i] = 1;
            sd[i] = $urandom;
          end else if ($urandom_range(0, 9) == 0) begin
            sa[i] = 0;
            sv[i] = 1;
            sd[i] = $urandom;
          end
        end
        set_src(i, sv[i], sa[i], sd[i]);
      end
      iv  = ($urandom_range(0, 2) != 0);
      wen = $urandom_range(0, 1) == 1;
      rd  = 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      set_issue(iv, wen, rd, r1, r2);
`ifdef REGS_WB_FWD_EN
      rs1_di = $urandom;
      rs2_di = $urandom;
`endif
      g = -1;
      for (int n = 1; n <= 3; n++) begin
        j = (last + n) % 3;
        if (g < 0 && sv[j]) g = j;
      end
`ifdef REGS_WB_FWD_EN
      es = iv && ((r1 != 0 && mb[r1] && !(men && maddr == r1))
               || (r2 != 0 && mb[r2] && !(men && maddr == r2))
               || (wen && rd != 0 && mb[rd]));
`else
      es = iv && ((r1 != 0 && mb[r1]) || (r2 != 0 && mb[r2])
               || (wen && rd != 0 && mb[rd]));
`endif
      #1;
      checks++; if (src_ready !== ((g < 0) ? 3'b000 : 3'(1 << g))) begin errors++;
        $display("FAIL rnd_ready c=%0d: got %b expected grant %0d", c, src_ready, g); end
      checks++; if (issue_stall !== es) begin errors++;
        $display("FAIL rnd_stall c=%0d: got %b expected %b", c, issue_stall, es); end
`ifdef REGS_WB_FWD_EN
      checks++; if (rs1_do !== ((men && maddr == r1) ? mdata : rs1_di)
                    || rs2_do !== ((men && maddr == r2) ? mdata : rs2_di)) begin errors++;
        $display("FAIL rnd_fwd c=%0d: got %h %h", c, rs1_do, rs2_do); end
`endif
      acc = iv && !es;
      tick();
      if (men) mb[maddr] = 0;
      if (acc && wen && rd != 0) begin
        mb[rd] = 1;
        pend.push_back(rd);
      end
      if (g >= 0) begin
        men   = (sa[g] != 0);
        maddr = sa[g];
        mdata = sd[g];
        sv[g] = 0;
        last  = g;
      end else begin
        men = 0;
      end
      for (int i = 0; i < 32; i++) eb[i] = mb[i];
      checks++; if (busy !== eb) begin errors++;
        $display("FAIL rnd_busy c=%0d: got %h expected %h", c, busy, eb); end
      checks++; if (wr_en !== men || (men && (wr_addr !== maddr || wr_data !== mdata))) begin
        errors++;
        $display("FAIL rnd_wport c=%0d: got en=%b a=%0d d=%h expected en=%b a=%0d d=%h",
                 c, wr_en, wr_addr, wr_data, men, maddr, mdata); end
    end
    src_valid = '0;
    set_issue(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_raw_stall();
    test_x0();
    test_waw();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regs_wb_ctrl.md
# regs_wb_ctrl

Write-back controller and hazard scoreboard for the integer register file. It arbitrates the single register-file write port between up to `NUM_SRC` result producers (ALU, LSU, MDU), using round-robin with a valid/ready handshake. It tracks pending writes per architectural register and stalls issue on RAW and WAW hazards. It sits between the execute units and `regs_file`, driving that block's write port.

## Interface
Parameters:
- `CPU_WIDTH`, 32: data width.
- `REG_ADDR_WIDTH`, 5: register address width.
- `REG_DATA_DEPTH`, 32: number of architectural registers.
- `NUM_SRC`, 3: number of write-back requesters (2..4).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: an instruction is presented for issue.
- `issue_rd_wen_i` in 1: the instruction writes `rd`.
- `issue_rd_i` in `REG_ADDR_WIDTH`: destination register.
- `issue_rs1_i`, `issue_rs2_i` in `REG_ADDR_WIDTH`: source registers.
- `issue_stall_o` out 1: issue blocked by a hazard.
- `src_valid_i` in `NUM_SRC`: result valid, one bit per source.
- `src_addr_i` in `NUM_SRC*REG_ADDR_WIDTH`: flattened destination addresses; source i occupies slice i.
- `src_data_i` in `NUM_SRC*CPU_WIDTH`: flattened result data.
- `src_ready_o` out `NUM_SRC`: one-hot grant.
- `reg_wr_en_o` out 1: write enable to the register file.
- `reg_wr_adder_o` out `REG_ADDR_WIDTH`: write address.
- `reg_wr_data_o` out `CPU_WIDTH`: write data.
- `busy_o` out `REG_DATA_DEPTH`: scoreboard vector.
- Present only with `REGS_WB_FWD_EN`:
  - `rs1_data_i`, `rs2_data_i` in `CPU_WIDTH`: register-file read data.
  - `rs1_data_o`, `rs2_data_o` out `CPU_WIDTH`: forwarded read data.

## Operation
- **Issue accept.** Issue is accepted when `issue_valid_i && !issue_stall_o`. On accept with `issue_rd_wen_i` and `issue_rd_i != 0`, set `busy[issue_rd_i]`.
- **Stall.** `issue_stall_o = issue_valid_i && (H1 || H2 || HW)`.
  - `Hn = (rsN != 0) && busy[rsN]` (RAW).
  - `HW = issue_rd_wen_i && (rd != 0) && busy[rd]` (WAW).
  - Result: at most one outstanding write per register.
- **x0.** `busy[0]` is permanently 0.
- **Arbitration.**
  - Round-robin pointer `last` holds the most recently granted source.
  - Priority order is `last+1, last+2, …`, wrapping modulo `NUM_SRC`.
  - `src_ready_o` is combinational from `src_valid_i` and `last`: one-hot, or zero if no source is valid.
  - `last` updates only on a grant.
- **Handshake.** A transfer occurs when `src_valid_i[i] && src_ready_o[i]`. Sources hold valid, address and data stable until ready. Ready never depends on `issue_*`.
- **Write port.** The granted address and data are registered into `reg_wr_*_o`. `reg_wr_en_o` is 1 the cycle after the handshake, only if the address is non-zero. A handshake to x0 completes normally and is discarded.
- **Scoreboard clear.** `busy[reg_wr_adder_o]` clears at the clock edge ending a cycle with `reg_wr_en_o = 1`; this is the same edge at which `regs_file` commits the write.
- **Set and clear on the same edge.** If a set and a clear target the same register on one edge, the set wins. This cannot occur legally because of WAW stalling, but the RTL must still implement it.
- **Illegal results.** A result arriving for a register that is not busy is still written; an assertion flags it in simulation.

## Timing
- **Reset values.** `busy_o = 0`, `reg_wr_en_o = 0`, `reg_wr_adder_o = 0`, `reg_wr_data_o = 0`, `last = NUM_SRC-1` (source 0 has first priority), `src_ready_o = 0`.
- **Reset mid-operation.** All pending state and in-flight results are lost; the producers are reset together with this block.
- **Latency, handshake to register file.** 1 cycle.
- **Latency, handshake to busy clear.** 2 edges.
- **Throughput.** One write per cycle. With all sources continuously valid, each source is granted once every `NUM_SRC` cycles.
- **Issue latency without forwarding.** A dependent instruction issues in the cycle after `reg_wr_en_o`, i.e. the handshake cycle + 2.

## Configuration
- `REGS_WB_FWD_EN` defined:
  - `Hn` is suppressed when `reg_wr_en_o && reg_wr_adder_o == rsN`.
  - In that case `rsN_data_o = reg_wr_data_o`; otherwise `rsN_data_o = rsN_data_i`.
  - A dependent instruction issues one cycle earlier, in the `reg_wr_en_o` cycle.
  - WAW stalling is unchanged.
- Undefined: the forwarding ports and logic are absent.

## Structure
- **Shared defines.** `CPU_WIDTH`, `REG_ADDR_WIDTH`, `REG_DATA_DEPTH` and the source index constants (`SRC_ALU = 0`, `SRC_LSU = 1`, `SRC_MDU = 2`) belong in the shared defines file.
- **Sub-module.** `rr_arbiter` (`NUM_SRC`-wide round-robin, valid in / one-hot grant out, pointer update on grant) is the one natural sub-module and is reusable for memory-port sharing.

## Test plan
- **Single write.** Issue `rd = 5` with `rs = 0` → `busy_o[5] = 1` next cycle. ALU result 0xDEADBEEF to x5 → `reg_wr_en_o = 1`, addr 5, data 0xDEADBEEF one cycle later; `busy_o[5] = 0` after the following edge.
- **RAW stall.** With x7 busy, issue `rs2 = 7` → `issue_stall_o = 1` until the write-back. Without `REGS_WB_FWD_EN`, the stall drops the cycle after `reg_wr_en_o`. With it, the stall drops in the `reg_wr_en_o` cycle and `rs2_data_o` equals the written data.
- **Round-robin fairness.** All three sources valid for 6 cycles from reset → grants in order 0, 1, 2, 0, 1, 2.
- **x0 handling.** A source writes x0 with data 0x1234 → handshake completes, `reg_wr_en_o` stays 0, `busy_o[0]` stays 0.
- **WAW stall.** x3 busy, issue with `rd = 3` → stall. After the write-back the issue is accepted and `busy_o[3]` re-sets.
- **Reset mid-operation.** Assert `rst_n = 0` with x4 and x9 busy and a write pending → all outputs 0 immediately; after release, source 0 is granted first.
